bin2bcd_seq: RTL
================

# bin2bcd_seq

Parametrised, sequential binary-to-BCD converter for the 7-segment display path: a generalised successor to the 16-bit `mru` unit. It latches a DATA_W-bit value on `set` and converts it on `getData` using shift-and-add-3, one bit per cycle. It publishes a DIGITS-nibble BCD word with a one-cycle `valid` strobe. Conversions are rate-limited by MAX_RATE, and a compile-time option adds a signed mode with a sign flag.

## Interface
- DATA_W, 16, width of binary input (≥2)
- DIGITS, 5, BCD digits out; elaboration error unless 10^DIGITS > 2^DATA_W − 1
- MAX_RATE, 0, idle cycles enforced after each `valid` before a new `getData` is accepted
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset: synchronous, active-low
- enable  in  1  global clock enable; 0 freezes all state and outputs
- set  in  1  latch `data` into holding register
- data  in  DATA_W  binary value
- getData  in  1  request conversion of holding register
- dataToOut  out  4*DIGITS  BCD result, digit 0 in bits [3:0]
- valid  out  1  one-cycle pulse when `dataToOut` updates
- busy  out  1  high whenever `getData` would be ignored
- neg  out  1  sign of last result (0 when SIGNED_MODE_EN undefined)

## Operation
- Reset (rst_n=0 at an edge): holding reg=0, `dataToOut`=0, `valid`=0, `busy`=0, `neg`=0, state IDLE, rate counter=0. Reset wins over `enable`. Reset mid-conversion aborts it with no `valid`.
- `enable`=0: no state, counter, register or output changes; `set`/`getData` ignored; a `valid` already high stays high until the next enabled edge.
- `set`: holding reg ← `data`. Accepted in any state; never disturbs a running conversion.
- States:
  - IDLE: `getData`=1 and rate counter=0 → load shift reg with holding value (pre-`set` value if `set` is in the same cycle), clear BCD scratch, bit count=DATA_W → SHIFT.
  - SHIFT: each enabled cycle, every BCD nibble ≥5 gets +3, then {BCD,shift} shifts left by 1 and count decrements. At count=1 the last shift completes → DONE.
  - DONE (one cycle): `dataToOut` ← scratch, `valid`=1, counter ← MAX_RATE → IDLE.
- Rate counter decrements once per enabled cycle in IDLE while nonzero.
- `busy` = (state≠IDLE) or (counter≠0). `getData` while busy is dropped, not queued.
- No overflow is possible given the DIGITS check. `dataToOut` holds its value between conversions.

## Timing
- `getData` sampled at edge k → SHIFT edges k+1..k+DATA_W. `dataToOut`/`valid` change at edge k+DATA_W+1. Latency DATA_W+1 enabled cycles; disabled cycles stretch it 1:1.
- `busy` rises at edge k+1 and falls at the edge after the counter reaches 0. With MAX_RATE=0, that is the edge after `valid`, which is the earliest next accept.
- Throughput: one conversion per DATA_W+2+MAX_RATE enabled cycles.

## Configuration
- SIGNED_MODE_EN defined: the holding value is two's complement. At accept, the shift reg is loaded with |value| as DATA_W-bit unsigned, so −2^(DATA_W−1) maps to 2^(DATA_W−1). The sign is captured and `neg` updates together with `dataToOut`. −0 cannot occur.
- SIGNED_MODE_EN undefined: unsigned conversion; `neg` tied 0; no abs logic present.

## Structure
- Package `bin2bcd_pkg`: state enum (IDLE, SHIFT, DONE), constant ADD3_THRESH=5, function `min_digits(width)` used in the DIGITS elaboration check.
- Sub-module `bcd_adj_nibble`: combinational 4-bit ≥5→+3 corrector, instantiated DIGITS times via generate.
- Top holds FSM, bit counter ($clog2(DATA_W+1) bits), rate counter ($clog2(MAX_RATE+1) bits, min 1), and shift/scratch registers.

## Test plan
- Defaults: reset, `set` with data=65233, then `getData` → `valid` exactly 17 cycles later, `dataToOut`=20'h65233, `busy` high 17 cycles.
- Corners: data=0 → 20'h00000; data=65535 → 20'h65535; DATA_W=8/DIGITS=3, data=255 → 12'h255.
- MAX_RATE=3: `getData` held high continuously → `valid` pulses spaced 21 cycles; `getData` during SHIFT/holdoff has no effect.
- `set` data=1234 while converting 9999 → result 20'h09999; the next `getData` → 20'h01234. Same-cycle `set`+`getData` converts the old value.
- `rst_n`=0 at cycle 8 of a conversion → all outputs 0 next edge, no `valid`. `enable`=0 for 5 cycles mid-SHIFT → `valid` delayed exactly 5 cycles with a correct result.
- SIGNED_MODE_EN: data=16'hFFFF → `neg`=1, 20'h00001; 16'h8000 → `neg`=1, 20'h32768; 16'd32767 → `neg`=0, 20'h32767.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int ADD3_THRESH = 5;

  // Smallest digit count d with 10^d > 2^width - 1 (width up to 63).
  function automatic int min_digits(input int width);
    longint unsigned one;
    longint unsigned max_val;
    longint unsigned pow;
    int d;
    one     = 64'd1;
    max_val = (one << width) - one;
    pow     = one;
    d       = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow <= max_val) begin
        pow = pow * 64'd10;
        d   = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// One BCD digit corrector for shift-and-add-3: nibbles >= 5 get +3 before the shift.
module bcd_adj_nibble
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'(ADD3_THRESH)) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Optional signed conversion with sign flag when SIGNED_MODE_EN is defined.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DIGITS   = 5,
  parameter int MAX_RATE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                set,
  input  logic [DATA_W-1:0]   data,
  input  logic                getData,
  output logic [4*DIGITS-1:0] dataToOut,
  output logic                valid,
  output logic                busy,
  output logic                neg
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int RATE_W = (MAX_RATE > 0) ? $clog2(MAX_RATE + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(DATA_W);
  localparam logic [RATE_W-1:0] RATE_LOAD = RATE_W'(MAX_RATE);

  if (DATA_W < 2) begin : g_width_chk
    $error("bin2bcd_seq: DATA_W must be at least 2");
  end
  if (DIGITS < min_digits(DATA_W)) begin : g_digits_chk
    $error("bin2bcd_seq: DIGITS too small to hold 2^DATA_W-1");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q,  hold_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]  bcd_q,   bcd_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [RATE_W-1:0] rate_q,  rate_d;
  logic [BCD_W-1:0]  out_q,   out_d;
  logic              valid_q, valid_d;

  logic [BCD_W-1:0]  bcd_adj;
  logic [DATA_W-1:0] load_val;
  logic              adj_msb_unused;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_adj_nibble u_adj (
      .din  (bcd_q[4*i +: 4]),
      .dout (bcd_adj[4*i +: 4])
    );
  end
  // The top digit never reaches >= 8 after correction, so its MSB is always shifted out as 0.
  assign adj_msb_unused = bcd_adj[BCD_W-1];

`ifdef SIGNED_MODE_EN
  logic sign_q, sign_d;
  logic neg_q,  neg_d;
  assign load_val = hold_q[DATA_W-1] ? (~hold_q + DATA_W'(1)) : hold_q;
  assign neg      = neg_q;
`else
  assign load_val = hold_q;
  assign neg      = 1'b0;
`endif

  // Handshake: getData is a request, not a valid/ready pair. It is honoured only on an
  // enabled edge where busy=0; otherwise it is dropped. valid is a one-enabled-cycle strobe.
  assign busy      = (state_q != IDLE) || (rate_q != '0);
  assign valid     = valid_q;
  assign dataToOut = out_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    out_d   = out_q;
    valid_d = valid_q;
`ifdef SIGNED_MODE_EN
    sign_d  = sign_q;
    neg_d   = neg_q;
`endif
    if (enable) begin
      valid_d = 1'b0;
      if (set) hold_d = data;
      case (state_q)
        IDLE: begin
          if (rate_q != '0) begin
            rate_d = rate_q - RATE_W'(1);
          end else if (getData) begin
            shift_d = load_val;
            bcd_d   = '0;
            cnt_d   = CNT_LOAD;
            state_d = SHIFT;
`ifdef SIGNED_MODE_EN
            sign_d  = hold_q[DATA_W-1];
`endif
          end
        end
        SHIFT: begin
          bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
        DONE: begin
          out_d   = bcd_q;
          valid_d = 1'b1;
          rate_d  = RATE_LOAD;
          state_d = IDLE;
`ifdef SIGNED_MODE_EN
          neg_d   = sign_q;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      rate_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
`ifdef SIGNED_MODE_EN
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      out_q   <= out_d;
      valid_q <= valid_d;
`ifdef SIGNED_MODE_EN
      sign_q  <= sign_d;
      neg_q   <= neg_d;
`endif
    end
  end

endmodule
